// File: rtl/pipe_hazard_ctrl.sv
// Load-use / RAW hazard and branch-flush controller for a 4-stage-visible pipeline, clocked on the falling edge.
// Optional statistics counters are built only when PIPE_HAZARD_STATS_EN is defined.
module pipe_hazard_ctrl (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] id_ir,
    input  logic        mem_taken,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    logic [3:0] op;
    logic [1:0] rs, rt, rd;
    logic       rs_use, rt_use, dst_vld;
    logic [1:0] dst_reg;
    logic       hazard, flush, stall;

    // Scoreboard: s1 = ID/EX, s2 = EX/MEM, s3 = MEM/WB.
    logic       s1_vld, s2_vld, s3_vld;
    logic [1:0] s1_reg, s2_reg, s3_reg;

    function automatic logic slot_hit(input logic vld, input logic [1:0] slot_reg,
                                      input logic use_src, input logic [1:0] src);
        return vld && use_src && (slot_reg == src);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    always_comb begin
        op      = id_ir[15:12];
        rs      = id_ir[11:10];
        rt      = id_ir[9:8];
        rd      = id_ir[7:6];
        rs_use  = (op <= 4'hB) && (rs != 2'd0);
        rt_use  = ((op <= 4'h6) || (op >= 4'h9 && op <= 4'hB)) && (rt != 2'd0);
        dst_vld = 1'b0;
        dst_reg = 2'd0;
        if (op <= 4'h6) begin
            dst_vld = (rd != 2'd0);
            dst_reg = rd;
        end else if (op == 4'h7 || op == 4'h8) begin
            dst_vld = (rt != 2'd0);
            dst_reg = rt;
        end
    end

    // Slots are cleared asynchronously, so hazard already drops to 0 in reset.
    assign hazard = slot_hit(s1_vld, s1_reg, rs_use, rs) || slot_hit(s1_vld, s1_reg, rt_use, rt)
                 || slot_hit(s2_vld, s2_reg, rs_use, rs) || slot_hit(s2_vld, s2_reg, rt_use, rt)
                 || slot_hit(s3_vld, s3_reg, rs_use, rs) || slot_hit(s3_vld, s3_reg, rt_use, rt);
    assign flush  = mem_taken && reset_n;
    assign stall  = hazard && !flush;

    assign pc_hold     = stall;
    assign ifid_hold   = stall;
    assign idex_bubble = stall;
    assign ifid_flush  = flush;
    assign idex_flush  = flush;

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s3_vld <= 1'b0;
        end else begin
            s3_vld <= s2_vld;
            s2_vld <= s1_vld && !flush;
            s1_vld <= dst_vld && !flush && !hazard;
        end
    end

    always_ff @(negedge clock) begin
        s3_reg <= s2_reg;
        s2_reg <= s1_reg;
        s1_reg <= dst_reg;
    end

`ifdef PIPE_HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (stall) stall_cnt_q <= sat_inc(stall_cnt_q);
            if (flush) flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 16'd0;
    assign flush_cnt = 16'd0;
`endif

endmodule
